// File: rtl/display_mux_7seg.sv
// Multiplexed 7-segment display driver: shadowed digit codes, hex decode,
// leading-zero blanking, per-digit decimal point, 16-level brightness PWM.
module display_mux_7seg #(
    parameter int NUM_DIGITS     = 4,
    parameter int SUB_DIV        = 3125,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    hex_en,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [7:0]              codigo,
    output logic [NUM_DIGITS-1:0]   seleccion,
    output logic                    frame_tick
);

    localparam int SUB_W  = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(SUB_DIV - 1);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = AN_ACTIVE_LOW ? '1 : '0;

    // Active-low a..g pattern; codes 10..15 are blank unless hex is enabled.
    function automatic logic [6:0] dec7(input logic [3:0] n, input logic hex);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b0000001;
            4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;
            4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;
            4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;
            4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;
            4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;
            default: p = 7'b0111000;
        endcase
        if (!hex && (n >= 4'hA)) begin
            p = 7'b1111111;
        end
        return p;
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [SUB_W-1:0]        sub_q, sub_d;
    logic [3:0]              phase_q, phase_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [3:0]              bright_q, bright_d;
    logic                    pend_q, pend_d;
    logic [7:0]              codigo_q, codigo_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    tick_q;

    logic                  sub_end, slot_end, en;
    logic [3:0]            nib;
    logic                  dp_bit, upper_zero, lz_blank;
    logic [7:0]            seg_al;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        sub_end  = (sub_q == SUB_LAST);
        slot_end = sub_end && (phase_q == 4'hF);
        sub_d    = sub_end ? '0 : sub_q + 1'b1;
        phase_d  = sub_end ? phase_q + 4'd1 : phase_q;
        slot_d   = slot_q;
        if (slot_end) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        // Brightness is only resampled at slot boundaries so a slot never changes duty mid-way.
        bright_d = slot_end ? brightness : bright_q;
        pend_d   = slot_end && (slot_q == SLOT_LAST);
        shadow_d = load ? digits_in : shadow_q;
        dp_d     = load ? dp_in : dp_q;
    end

    // Scan from the top digit down so upper_zero covers digit k and everything above it.
    always_comb begin
        nib        = 4'h0;
        dp_bit     = 1'b0;
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (shadow_q[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
            if (SLOT_W'(k) == slot_q) begin
                nib      = shadow_q[4*k +: 4];
                dp_bit   = dp_q[k];
                lz_blank = upper_zero && (k != 0);
            end
        end
    end

    always_comb begin
        en       = (phase_q <= bright_q);
        seg_al   = {~dp_bit, (blank_lz && lz_blank) ? 7'b1111111 : dec7(nib, hex_en)};
        onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << slot_q;
        codigo_d = SEG_OFF;
        sel_d    = SEL_OFF;
        if (en) begin
            codigo_d = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
            sel_d    = AN_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= '0;
            dp_q     <= '0;
            sub_q    <= '0;
            phase_q  <= '0;
            slot_q   <= '0;
            bright_q <= 4'hF;
            pend_q   <= 1'b0;
            codigo_q <= SEG_OFF;
            sel_q    <= SEL_OFF;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            dp_q     <= dp_d;
            sub_q    <= sub_d;
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            bright_q <= bright_d;
            pend_q   <= pend_d;
            codigo_q <= codigo_d;
            sel_q    <= sel_d;
            tick_q   <= pend_q;
        end
    end

    assign codigo     = codigo_q;
    assign seleccion  = sel_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed bench for display_mux_7seg: 4 digits, 2 clocks per brightness phase
// (32-cycle slots, 128-cycle frames); k counts clocks since reset release.
module tb_display_mux_7seg;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        hex_en;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [7:0]  codigo;
    logic [3:0]  seleccion;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    int ticks = 0;
    int first_tick = -1;
    int act = 0;

    display_mux_7seg #(
        .NUM_DIGITS(4),
        .SUB_DIV(2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .load(load),
        .hex_en(hex_en),
        .blank_lz(blank_lz),
        .brightness(brightness),
        .codigo(codigo),
        .seleccion(seleccion),
        .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic tick1();
        @(posedge CLK);
        #1;
        k++;
        if (frame_tick === 1'b1) begin
            ticks++;
            if (first_tick < 0) first_tick = k;
        end
        if (seleccion !== 4'hF) act++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick1();
    endtask

    initial begin
        RST = 1'b1; digits_in = 16'h0; dp_in = 4'h0; load = 1'b0;
        hex_en = 1'b0; blank_lz = 1'b0; brightness = 4'hF;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check("rst_codigo", codigo, 8'hFF);
        check("rst_sel", seleccion, 4'b1111);
        check("rst_tick", frame_tick, 1'b0);

        // Release and load 4321 in the same cycle; first output still sees shadow 0.
        RST = 1'b0; load = 1'b1; digits_in = 16'h4321;
        tick1();
        load = 1'b0;
        check("rel_sel", seleccion, 4'b1110);
        check("rel_codigo", codigo, 8'h81);

        run_to(17);  check("scan0_codigo", codigo, 8'hCF); check("scan0_sel", seleccion, 4'b1110);
        run_to(49);  check("scan1_codigo", codigo, 8'h92); check("scan1_sel", seleccion, 4'b1101);
        run_to(81);  check("scan2_codigo", codigo, 8'h86); check("scan2_sel", seleccion, 4'b1011);
        run_to(113); check("scan3_codigo", codigo, 8'hCC); check("scan3_sel", seleccion, 4'b0111);
        run_to(260);
        check("tick_count", ticks, 2);
        check("tick_first", first_tick, 129);

        // Blanking / hex: 00A5 loaded mid-frame, checked in the following frame.
        digits_in = 16'h00A5; blank_lz = 1'b1; hex_en = 1'b0; load = 1'b1;
        tick1();
        load = 1'b0;
        run_to(401); check("blk_d0", codigo, 8'hA4);
        run_to(433); check("blk_d1_nohex", codigo, 8'hFF); check("blk_d1_sel", seleccion, 4'b1101);
        run_to(465); check("blk_d2", codigo, 8'hFF);
        run_to(497); check("blk_d3", codigo, 8'hFF);
        hex_en = 1'b1;
        run_to(561); check("hex_d1", codigo, 8'h88);
        run_to(593); check("hex_d2_lz", codigo, 8'hFF);

        digits_in = 16'h0000; load = 1'b1;
        tick1();
        load = 1'b0;
        run_to(657); check("zero_d0", codigo, 8'h81);
        run_to(689); check("zero_d1", codigo, 8'hFF);
        run_to(753); check("zero_d3", codigo, 8'hFF);

        // Brightness 3 latched at the next boundary; a mid-slot change waits a slot.
        brightness = 4'd3;
        run_to(768); act = 0;
        run_to(800); check("bright3_slot0", act, 8);
        act = 0;
        run_to(810); brightness = 4'd7;
        run_to(832); check("bright_midslot", act, 8);
        act = 0;
        run_to(864); check("bright7_slot2", act, 16);
        brightness = 4'hF;

        // Load coincident with the slot boundary edge (counter 895 -> 896).
        run_to(895);
        digits_in = 16'h4321; dp_in = 4'b0100; load = 1'b1;
        tick1();
        load = 1'b0; digits_in = 16'h8888; dp_in = 4'b0000;
        tick1();
        check("load_boundary_d0", codigo, 8'hCF);
        run_to(913); check("dp_d0_unlit", codigo, 8'hCF);
        run_to(977); check("dp_d2_lit", codigo, 8'h06);

        // Reset at slot 2, phase 5 (counter index 1098).
        run_to(1098);
        RST = 1'b1;
        tick1();
        check("mid_rst_codigo", codigo, 8'hFF);
        check("mid_rst_sel", seleccion, 4'b1111);
        check("mid_rst_tick", frame_tick, 1'b0);
        RST = 1'b0;
        tick1();
        check("restart_sel", seleccion, 4'b1110);
        check("restart_codigo", codigo, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_mux_7seg.md
Name: display_mux_7seg

Overview:
- Parametrised multiplexed 7-segment display driver for the DPWM front panel (Nexys 3 class boards).
- Captures NUM_DIGITS packed 4-bit digit codes into a shadow register and time-multiplexes them onto one shared segment bus plus per-digit select lines.
- Adds features beyond a fixed 4-digit decoder: hex mode, leading-zero blanking, per-digit decimal point, 16-level brightness PWM, configurable polarity and a frame-complete strobe.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- SUB_DIV, 3125: CLK cycles per brightness phase. Slot = 16*SUB_DIV cycles, which gives 2 kHz per digit slot at 100 MHz.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp bit driven 0 when lit.
- AN_ACTIVE_LOW, 1: 1 = the selected digit's `seleccion` bit is driven 0.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- digits_in  in  4*NUM_DIGITS  packed digit codes; digit 0 = LSBs = rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- load  in  1  one-cycle strobe; captures digits_in and dp_in into the shadow registers
- hex_en  in  1  1 = show codes 10..15 as A,b,C,d,E,F; 0 = show them blank
- blank_lz  in  1  1 = leading-zero blanking enabled
- brightness  in  4  on-time is (brightness+1)/16 of each slot
- codigo  out  8  {dp,a,b,c,d,e,f,g}, registered
- seleccion  out  NUM_DIGITS  one-hot digit select, registered
- frame_tick  out  1  one-cycle pulse when slot index wraps from NUM_DIGITS-1 to 0

Behaviour:
- Reset (RST=1 at a CLK edge) clears the following, takes effect the next cycle, and applies mid-frame too:
  - shadow digits and dp: 0
  - sub counter, phase counter, slot index: 0
  - brightness latch: 15
  - codigo: all segments off (8'hFF if SEG_ACTIVE_LOW, else 8'h00)
  - seleccion: all inactive
  - frame_tick: 0
- Shadow load:
  - On load=1, shadow <= digits_in and dp_in.
  - If load is not asserted, the shadow holds its value indefinitely.
  - A load in the same cycle as a slot change is legal; the new value is visible from the following cycle.
- Timing chain:
  - sub counter runs 0..SUB_DIV-1.
  - At the sub counter's terminal value, the phase counter (0..15) increments.
  - When phase=15 and sub=SUB_DIV-1, the slot index advances (mod NUM_DIGITS) and phase wraps to 0.
  - The brightness latch samples `brightness` at that same slot boundary, so it never changes mid-slot.
- Enable:
  - Digit enable = (phase <= brightness latch).
  - With brightness=15 the selected digit is on for the entire slot.
- Decode of the slot's shadow nibble, active-low form, bits a..g:
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - 9: 0000100
  - A: 0001000
  - b: 1100000
  - C: 0110001
  - d: 1000010
  - E: 0110000
  - F: 0111000
  - When hex_en=0, codes 10..15 decode as blank (1111111).
- Leading-zero blanking (blank_lz=1): digit k (k>=1) is blanked when its nibble and all nibbles above k are 0. Digit 0 is never blanked.
- Decimal point: dp bit is lit iff dp_in[k] for the slot's digit is set. This is independent of blanking.
- Polarity: if SEG_ACTIVE_LOW=0, the whole codigo byte is inverted. If AN_ACTIVE_LOW=0, seleccion is active-high.
- Output registers, 1-cycle latency from counter state:
  - enabled: seleccion = one-hot(slot) in the selected polarity; codigo = decoded pattern.
  - disabled: seleccion all inactive; codigo all off.
  - Exactly one select is active at a time. No select is active on the cycle following a slot change's phase-0 compute edge, unless enabled.
- frame_tick: asserted for exactly one cycle, aligned with the first output cycle of slot 0 after a wrap. It is not asserted out of reset.

Test Plan:
- Reset/idle: NUM_DIGITS=4, SUB_DIV=2, assert RST 3 cycles -> codigo=8'hFF, seleccion=4'b1111, frame_tick=0. Release -> slot 0 selected (4'b1110) after 1 cycle, codigo=8'h81 (digit 0, shadow=0).
- Scan/decode: load digits_in=16'h4321, brightness=15 -> slots 0..3 each last 32 cycles. codigo = 8'hCF, 8'h92, 8'h86, 8'hCC with seleccion 1110, 1101, 1011, 0111. frame_tick pulses once every 128 cycles.
- Blanking/hex: digits_in=16'h00A5:
  - hex_en=0, blank_lz=1 -> digit1 8'hFF, digits 2/3 blanked 8'hFF, digit0 8'hA4.
  - hex_en=1 -> digit1 8'h88.
  - digits_in=16'h0000, blank_lz=1 -> only digit0 shows 8'h81.
- Brightness: brightness=3 -> each slot's select active exactly 8 of 32 cycles (phases 0..3). Changing brightness mid-slot takes effect only from the next slot boundary.
- DP/load coherency: dp_in=4'b0100, load pulse coincident with a slot boundary -> digit 2 codigo bit7=0. Without load, changes on digits_in never reach codigo.
- Reset mid-operation: assert RST during slot 2, phase 5 -> next cycle all selects inactive and codigo=8'hFF. After release, the scan restarts at slot 0 with shadow=0.
